// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register addresses, widths,
// reset constants and a word-select helper.
package mtimer_pkg;

  localparam int unsigned MTIME_W  = 64;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned PRESC_W  = 16;

  localparam logic [1:0] MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMECMP_HI = 2'd3;

  localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Select the upper (hi=1) or lower (hi=0) 32-bit half of a 64-bit value.
  function automatic logic [WORD_W-1:0] word_of(input logic [MTIME_W-1:0] v,
                                                input logic hi);
    logic [WORD_W-1:0] w;
    if (hi) begin
      w = v[63:32];
    end else begin
      w = v[31:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: counts 0..DIV-1 and flags tick while at DIV-1.
// clear forces the count back to 0 on the next edge and beats the wrap.
module mtimer_prescaler
  import mtimer_pkg::*;
#(
  parameter int unsigned DIV       = 1,
  parameter int unsigned BASE_TICK = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(DIV - 1);
  localparam logic [PRESC_W-1:0] INIT = PRESC_W'(BASE_TICK);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_cnt_nxt;
  logic               w_tick;

  assign w_tick = (r_cnt == LAST);
  assign tick   = w_tick;

  // Next count: clear wins, otherwise wrap on tick, otherwise advance.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Count register, reloaded with BASE_TICK on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= INIT;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Machine timer (mtime / mtimecmp) with a 4-word bus port and a registered
// interrupt-pending output.
// Optional feature: define MTIMER_SNAPSHOT_EN to latch mtime[63:32] into a
// shadow register on every MTIME_LO read; MTIME_HI reads then return the
// shadow, giving a tear-free 64-bit read sequence (LO then HI).
module mtimer
  import mtimer_pkg::*;
#(
  parameter int unsigned DIV       = 1,
  parameter int unsigned BASE_TICK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              ack,
  output logic              irq
);

  logic [MTIME_W-1:0] r_mtime;
  logic [MTIME_W-1:0] r_mtimecmp;
  logic [WORD_W-1:0]  r_dout;
  logic               r_ack;
  logic               r_irq;

  logic [MTIME_W-1:0] w_mtime_nxt;
  logic [MTIME_W-1:0] w_mtimecmp_nxt;
  logic [WORD_W-1:0]  w_rdata;
  logic               w_wr;
  logic               w_rd;
  logic               w_wr_mtime_lo;
  logic               w_wr_mtime_hi;
  logic               w_wr_cmp_lo;
  logic               w_wr_cmp_hi;
  logic               w_tick;

  assign w_wr          = req & we;
  assign w_rd          = req & ~we;
  assign w_wr_mtime_lo = w_wr & (addr == MTIME_LO);
  assign w_wr_mtime_hi = w_wr & (addr == MTIME_HI);
  assign w_wr_cmp_lo   = w_wr & (addr == MTIMECMP_LO);
  assign w_wr_cmp_hi   = w_wr & (addr == MTIMECMP_HI);

  mtimer_prescaler #(
    .DIV       (DIV),
    .BASE_TICK (BASE_TICK)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (w_wr_mtime_lo | w_wr_mtime_hi),
    .tick  (w_tick)
  );

`ifdef MTIMER_SNAPSHOT_EN
  logic [WORD_W-1:0] r_shadow;

  // Capture the high word whenever the low word is read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= 32'd0;
    end else if (w_rd && (addr == MTIME_LO)) begin
      r_shadow <= word_of(r_mtime, 1'b1);
    end else begin
      r_shadow <= r_shadow;
    end
  end
`endif

  // mtime next value: a bus write to either half beats the tick, and the
  // other half keeps its pre-increment value; the 64-bit add carries in-cycle.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr_mtime_lo) begin
      w_mtime_nxt = {r_mtime[63:32], din};
    end else if (w_wr_mtime_hi) begin
      w_mtime_nxt = {din, r_mtime[31:0]};
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end else begin
      w_mtime_nxt = r_mtime;
    end
  end

  // mtimecmp next value: only bus writes change it.
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr_cmp_lo) begin
      w_mtimecmp_nxt = {r_mtimecmp[63:32], din};
    end else if (w_wr_cmp_hi) begin
      w_mtimecmp_nxt = {din, r_mtimecmp[31:0]};
    end else begin
      w_mtimecmp_nxt = r_mtimecmp;
    end
  end

  // Read mux over the four words, using values present at the req edge.
  always_comb begin
    w_rdata = 32'd0;
    case (addr)
      MTIME_LO:    w_rdata = word_of(r_mtime, 1'b0);
`ifdef MTIMER_SNAPSHOT_EN
      MTIME_HI:    w_rdata = r_shadow;
`else
      MTIME_HI:    w_rdata = word_of(r_mtime, 1'b1);
`endif
      MTIMECMP_LO: w_rdata = word_of(r_mtimecmp, 1'b0);
      MTIMECMP_HI: w_rdata = word_of(r_mtimecmp, 1'b1);
      default:     w_rdata = 32'd0;
    endcase
  end

  // Timer state, bus response and interrupt level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
      r_ack      <= 1'b0;
      r_dout     <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_ack      <= req;
      r_irq      <= (r_mtime >= r_mtimecmp);
      if (w_rd) begin
        r_dout <= w_rdata;
      end else if (w_wr) begin
        r_dout <= 32'd0;
      end else begin
        r_dout <= r_dout;
      end
    end
  end

  assign dout = r_dout;
  assign ack  = r_ack;
  assign irq  = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: a DIV=1 instance and a DIV=4 instance.
// Expected read data is pushed to a scoreboard queue when an access is
// issued and popped when the ack comes back.
module tb_mtimer;
  import mtimer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [1:0]  addr;
  logic [31:0] din, dout;
  logic        ack, irq;
  logic        req4, we4;
  logic [1:0]  addr4;
  logic [31:0] din4, dout4;
  logic        ack4, irq4;

  logic [31:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  mtimer #(.DIV(1), .BASE_TICK(0)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .din(din), .dout(dout), .ack(ack), .irq(irq));

  mtimer #(.DIV(4), .BASE_TICK(0)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4),
    .din(din4), .dout(dout4), .ack(ack4), .irq(irq4));

  always #5 clk = ~clk;

  // One bus access, issued at a negedge; returns ack/dout one cycle later.
  task automatic bus(input bit sel4, input logic w, input logic [1:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic got);
    if (sel4) begin
      req4 = 1'b1; we4 = w; addr4 = a; din4 = d;
    end else begin
      req = 1'b1; we = w; addr = a; din = d;
    end
    @(negedge clk);
    if (sel4) begin
      req4 = 1'b0; we4 = 1'b0; got = ack4; rd = dout4;
    end else begin
      req = 1'b0; we = 1'b0; got = ack; rd = dout;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic got;
    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    req4 = 1'b0; we4 = 1'b0; addr4 = 2'd0; din4 = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || dout !== 32'd0 || irq !== 1'b0 ||
        ack4 !== 1'b0 || dout4 !== 32'd0 || irq4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dout=%h irq=%b ack4=%b dout4=%h irq4=%b, required all 0",
               ack, dout, irq, ack4, dout4, irq4);
    end
    // A write during reset must be ignored and never acked.
    bus(1'b0, 1'b1, MTIMECMP_LO, 32'd5, rd, got);
    n_checks++;
    if (got !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_write_ack: ack=%b required 0", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_release;
    logic [31:0] rd, exp;
    logic got;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL release_irq: irq=%b required 0", irq);
    end
    repeat (10) @(negedge clk);
    sb.push_back(32'd10);
    bus(1'b0, 1'b0, MTIME_LO, 32'd0, rd, got);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || rd !== exp) begin
      n_fail++;
      $display("FAIL release_mtime_lo: ack=%b dout=%h required ack=1 dout=%h", got, rd, exp);
    end
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      bus(1'b0, 1'b0, (i == 0) ? MTIMECMP_LO : MTIMECMP_HI, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL release_mtimecmp[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
  endtask

  task automatic test_irq;
    logic [31:0] rd, exp;
    logic got;
    logic [1:0]  wa[3];
    logic [31:0] wd[3];
    wa[0] = MTIME_LO;    wd[0] = 32'd0;
    wa[1] = MTIMECMP_HI; wd[1] = 32'd0;
    wa[2] = MTIMECMP_LO; wd[2] = 32'd20;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'd0);
      bus(1'b0, 1'b1, wa[i], wd[i], rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL irq_setup_write[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
    repeat (18) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: irq=%b required 0 while mtime first equals 20", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise: irq=%b required 1", irq);
    end
    sb.push_back(32'd0);
    bus(1'b0, 1'b1, MTIMECMP_LO, 32'hFFFF_FFFF, rd, got);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || rd !== exp || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_clear_write: ack=%b dout=%h irq=%b required ack=1 dout=%h irq=1", got, rd, irq, exp);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%b required 0", irq);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    sb.push_back(32'd0);
    sb.push_back(32'hFFFF_FFFF);
    req = 1'b1; we = 1'b0; addr = MTIMECMP_HI;
    @(negedge clk);
    addr = MTIMECMP_LO;
    exp = sb.pop_front();
    n_checks++;
    if (ack !== 1'b1 || dout !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: ack=%b dout=%h required ack=1 dout=%h", ack, dout, exp);
    end
    @(negedge clk);
    req = 1'b0;
    exp = sb.pop_front();
    n_checks++;
    if (ack !== 1'b1 || dout !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: ack=%b dout=%h required ack=1 dout=%h", ack, dout, exp);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || dout !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL b2b_hold: ack=%b dout=%h required ack=0 dout=ffffffff", ack, dout);
    end
  endtask

  task automatic test_carry;
    logic [31:0] rd, exp;
    logic got;
    sb.push_back(32'd0);
    sb.push_back(32'd0);
    bus(1'b0, 1'b1, MTIME_LO, 32'hFFFF_FFFF, rd, got);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || rd !== exp) begin
      n_fail++;
      $display("FAIL carry_wr_lo: ack=%b dout=%h required ack=1 dout=%h", got, rd, exp);
    end
    bus(1'b0, 1'b1, MTIME_HI, 32'd0, rd, got);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || rd !== exp) begin
      n_fail++;
      $display("FAIL carry_wr_hi: ack=%b dout=%h required ack=1 dout=%h", got, rd, exp);
    end
    @(negedge clk);
    sb.push_back(32'd0);
    sb.push_back(32'd1);
    for (int i = 0; i < 2; i++) begin
      bus(1'b0, 1'b0, (i == 0) ? MTIME_LO : MTIME_HI, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL carry_read[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] rd, exp;
    logic got;
    bus(1'b0, 1'b1, MTIME_HI, 32'd1, rd, got);
    bus(1'b0, 1'b1, MTIME_LO, 32'hFFFF_FFFF, rd, got);
    sb.push_back(32'hFFFF_FFFF);
`ifdef MTIMER_SNAPSHOT_EN
    sb.push_back(32'd1);
`else
    sb.push_back(32'd2);
`endif
    for (int i = 0; i < 2; i++) begin
      bus(1'b0, 1'b0, (i == 0) ? MTIME_LO : MTIME_HI, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL snapshot_read[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
  endtask

  task automatic test_div4;
    logic [31:0] rd, exp;
    logic got;
    bus(1'b1, 1'b1, MTIME_LO, 32'd0, rd, got);
    for (int k = 1; k <= 12; k++) begin
      sb.push_back(32'((k - 1) / 4));
      bus(1'b1, 1'b0, MTIME_LO, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL div4_rate[%0d]: ack=%b dout=%h required ack=1 dout=%h", k, got, rd, exp);
      end
    end
    // Next edge after three idle cycles is a tick edge: the write must win.
    repeat (3) @(negedge clk);
    bus(1'b1, 1'b1, MTIME_LO, 32'h100, rd, got);
    sb.push_back(32'h100);
    bus(1'b1, 1'b0, MTIME_LO, 32'd0, rd, got);
    exp = sb.pop_front();
    n_checks++;
    if (got !== 1'b1 || rd !== exp) begin
      n_fail++;
      $display("FAIL div4_write_on_tick: ack=%b dout=%h required ack=1 dout=%h", got, rd, exp);
    end
    // Write off a tick edge: the prescaler restarts from 0.
    bus(1'b1, 1'b1, MTIME_LO, 32'h200, rd, got);
    repeat (3) @(negedge clk);
    sb.push_back(32'h200);
    sb.push_back(32'h201);
    for (int i = 0; i < 2; i++) begin
      bus(1'b1, 1'b0, MTIME_LO, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL div4_presc_clear[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
  endtask

  task automatic test_reset_midread;
    logic [31:0] rd, exp;
    logic got;
    n_checks++;
    if (irq !== 1'b1 || dout === 32'd0) begin
      n_fail++;
      $display("FAIL midread_pre: irq=%b dout=%h required irq=1 and nonzero dout", irq, dout);
    end
    req = 1'b1; we = 1'b0; addr = MTIME_LO;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ack !== 1'b0 || dout !== 32'd0 || irq !== 1'b0 || dout4 !== 32'd0) begin
      n_fail++;
      $display("FAIL midread_async: ack=%b dout=%h irq=%b dout4=%h required all 0", ack, dout, irq, dout4);
    end
    @(negedge clk);
    req = 1'b0;
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_no_ack: ack=%b required 0", ack);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midread_late_ack: ack=%b required 0", ack);
    end
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'd0);
    for (int i = 0; i < 2; i++) begin
      bus(1'b0, 1'b0, (i == 0) ? MTIMECMP_LO : MTIME_HI, 32'd0, rd, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== 1'b1 || rd !== exp) begin
        n_fail++;
        $display("FAIL midread_after[%0d]: ack=%b dout=%h required ack=1 dout=%h", i, got, rd, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_irq();
    test_back_to_back();
    test_carry();
    test_snapshot();
    test_div4();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 Parameter DIV, default 1, means mtime increments once every DIV clk cycles (legal 1..65535).
REQ-002 Parameter BASE_TICK, default 0, means the initial value of the prescaler counter after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  bus access strobe, one cycle per access.
REQ-006 we  input  1  write qualifier, sampled with req.
REQ-007 addr  input  2  word select: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI.
REQ-008 din  input  32  write data, sampled with req & we.
REQ-009 dout  output  32  registered read data, valid while ack is high.
REQ-010 ack  output  1  one-cycle pulse acknowledging each req.
REQ-011 irq  output  1  machine timer interrupt pending level, feeding the core's mtip.

Function
REQ-012 mtime shall be a 64-bit counter advancing by 1 on each prescaler tick, wrapping from 2^64-1 to 0.
REQ-013 The prescaler shall count 0..DIV-1 and assert tick in the cycle it equals DIV-1, then return to 0; with DIV=1, tick is asserted every cycle.
REQ-014 mtimecmp shall be a 64-bit register, written only by the bus.
REQ-015 ack shall be asserted exactly one cycle after every cycle in which req is high; back-to-back req on consecutive cycles shall each be acked.
REQ-016 A read (req & ~we) shall place the addressed word, sampled at the req edge, on dout together with ack; dout shall hold its value when ack is low.
REQ-017 A write (req & we) shall update the addressed 32-bit half at the req edge; dout with that ack shall be 0.
REQ-018 A write to MTIME_LO or MTIME_HI shall take priority over a tick in the same cycle; the untouched half shall keep its pre-increment value.
REQ-019 A write to either mtime half shall also clear the prescaler to 0.
REQ-020 The increment carry from the low word into the high word shall be applied in the same cycle as the low-word wrap.
REQ-021 irq shall be registered: irq in cycle N+1 = (mtime >= mtimecmp), using the unsigned 64-bit register values in cycle N.
REQ-022 irq shall deassert on the cycle after a write makes mtimecmp greater than mtime; no other clear mechanism exists.
REQ-023 req with we high while reset is asserted shall be ignored.

Reset
REQ-024 While reset is high: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=BASE_TICK, irq=0, ack=0, dout=0, shadow=0.
REQ-025 An access in flight when reset asserts shall be dropped with no ack.

Configuration
REQ-026 With macro MTIMER_SNAPSHOT_EN defined, a read of MTIME_LO shall copy mtime[63:32] into a 32-bit shadow register at the same edge, and a read of MTIME_HI shall return the shadow register.
REQ-027 Without MTIMER_SNAPSHOT_EN, there is no shadow register, and a read of MTIME_HI returns live mtime[63:32].

Structure
REQ-028 Address constants (MTIME_LO..MTIMECMP_HI), the reset value of mtimecmp and the 64-bit width constant shall live in the shared defs include.
REQ-029 The prescaler shall be a separate sub-module, mtimer_prescaler (ports clk, reset, clear, tick), parameterised by DIV and BASE_TICK.

Verification
REQ-030 Reset release with DIV=1 -> irq=0, and after 10 cycles a MTIME_LO read returns 10 or 11, with ack on the cycle after req.
REQ-031 Write MTIMECMP_HI=0, MTIMECMP_LO=20 with mtime=0 -> irq rises on the cycle after mtime first reads 20; writing MTIMECMP_LO=0xFFFF_FFFF clears irq one cycle after the write.
REQ-032 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0 -> two cycles later mtime reads 0x1_0000_0000 or greater, confirming the carry.
REQ-033 DIV=4: mtime advances exactly 1 every 4 cycles; a write to MTIME_LO during a tick cycle leaves the written value, not the value plus 1.
REQ-034 MTIMER_SNAPSHOT_EN: mtime=0x0000_0001_FFFF_FFFF; read LO then HI -> returns 0xFFFF_FFFF then 1; without the macro, HI returns 2.
REQ-035 Assert reset mid-read -> no ack, and all outputs take their REQ-024 values immediately, before the next clk edge.
